// File: rtl/rs_decoder_7_5.sv
// Streaming RS(7,5) decoder over GF(8): receives 7 symbols, computes S1/S2 by Horner,
// corrects at most one symbol error, then streams out the 5 message symbols with status.
module rs_decoder_7_5 #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int N            = 7,
    parameter int K            = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SYMBOL_WIDTH-1:0] in_sym,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYMBOL_WIDTH-1:0] out_sym,
    output logic                    out_last,
    output logic                    err_corrected,
    output logic                    err_uncorrectable
);

    typedef enum logic [1:0] {RECV, CALC, SEND} state_t;

    state_t                  state;
    logic [SYMBOL_WIDTH-1:0] rbuf [N];
    logic [SYMBOL_WIDTH-1:0] cbuf [N];
    logic [SYMBOL_WIDTH-1:0] s1, s2;
    logic [2:0]              cnt, oidx, nidx;
    logic [2:0]              l1, l2, jexp, eexp, pos;
    logic [2:0]              emag;
    logic                    fix;

    // Bit order is {1, a, a^2}, so multiplying by a rotates with a feedback XOR.
    function automatic logic [2:0] mul_a(input logic [2:0] v);
        return {v[0], v[2] ^ v[0], v[1]};
    endfunction

    function automatic logic [2:0] mul_a2(input logic [2:0] v);
        return mul_a(mul_a(v));
    endfunction

    // Log index: 0 for the zero element, i for a^(i-1).
    function automatic logic [2:0] log_idx(input logic [2:0] v);
        case (v)
            3'b100:  return 3'd1;
            3'b010:  return 3'd2;
            3'b001:  return 3'd3;
            3'b110:  return 3'd4;
            3'b011:  return 3'd5;
            3'b111:  return 3'd6;
            3'b101:  return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] alog(input logic [2:0] e);
        case (e)
            3'd0:    return 3'b100;
            3'd1:    return 3'b010;
            3'd2:    return 3'b001;
            3'd3:    return 3'b110;
            3'd4:    return 3'b011;
            3'd5:    return 3'b111;
            3'd6:    return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] mod7(input logic [4:0] x);
        logic [4:0] r;
        if (x >= 5'd14)     r = x - 5'd14;
        else if (x >= 5'd7) r = x - 5'd7;
        else                r = x;
        return r[2:0];
    endfunction

    // Index offsets cancel: j = idx2-idx1, e-exponent = 2*idx1-idx2-1, both biased by +7.
    always_comb begin
        l1   = log_idx(s1);
        l2   = log_idx(s2);
        jexp = mod7(5'd7 + 5'(l2) - 5'(l1));
        eexp = mod7(5'd6 + {1'b0, l1, 1'b0} - 5'(l2));
        emag = alog(eexp);
        pos  = 3'd6 - jexp;
        fix  = (s1 != '0) && (s2 != '0);
        nidx = oidx + 3'd1;
        for (int unsigned i = 0; i < N; i++) begin
            cbuf[i] = rbuf[i] ^ ((fix && pos == 3'(i)) ? emag : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= RECV;
            in_ready          <= 1'b0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            out_sym           <= '0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
            s1                <= '0;
            s2                <= '0;
            cnt               <= '0;
            oidx              <= '0;
            for (int unsigned i = 0; i < N; i++) rbuf[i] <= '0;
        end else begin
            case (state)
                RECV: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        rbuf[cnt] <= in_sym;
                        s1        <= mul_a(s1) ^ in_sym;
                        s2        <= mul_a2(s2) ^ in_sym;
                        if (cnt == 3'(N - 1)) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= CALC;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                CALC: begin
                    for (int unsigned i = 0; i < N; i++) rbuf[i] <= cbuf[i];
                    out_sym           <= cbuf[0];
                    out_valid         <= 1'b1;
                    out_last          <= 1'b0;
                    err_corrected     <= fix;
                    err_uncorrectable <= (s1 == '0) != (s2 == '0);
                    oidx              <= '0;
                    state             <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (oidx == 3'(K - 1)) begin
                            out_valid         <= 1'b0;
                            out_last          <= 1'b0;
                            out_sym           <= '0;
                            err_corrected     <= 1'b0;
                            err_uncorrectable <= 1'b0;
                            s1                <= '0;
                            s2                <= '0;
                            oidx              <= '0;
                            in_ready          <= 1'b1;
                            state             <= RECV;
                        end else begin
                            oidx     <= nidx;
                            out_sym  <= rbuf[nidx];
                            out_last <= (nidx == 3'(K - 1));
                        end
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_decoder_7_5.sv
// Self-checking bench for rs_decoder_7_5: directed cases plus random blocks checked
// against a brute-force GF(8) reference decoder.
module tb_rs_decoder_7_5;

    typedef logic [6:0][2:0] word_t;

    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, out_valid, out_ready, out_last;
    logic       err_corrected, err_uncorrectable;
    logic [2:0] in_sym, out_sym;
    int         total = 0;
    int         bad   = 0;

    rs_decoder_7_5 #(.SYMBOL_WIDTH(3), .N(7), .K(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_last(out_last),
        .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable)
    );

    always #5 clk = ~clk;

    // Carry-less polynomial product in standard bit order, reduced by x^3+x+1.
    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] x, y;
        logic [4:0] p;
        x = {a[0], a[1], a[2]};
        y = {b[0], b[1], b[2]};
        p = '0;
        for (int i = 0; i < 3; i++) if (y[i]) p = p ^ (5'(x) << i);
        for (int i = 4; i >= 3; i--) if (p[i]) p = p ^ (5'b01011 << (i - 3));
        return {p[0], p[1], p[2]};
    endfunction

    // Evaluate r(x) where w[0] is the x^6 coefficient.
    function automatic logic [2:0] synd(input word_t w, input logic [2:0] x);
        logic [2:0] s, xp;
        s  = 3'b000;
        xp = 3'b100;
        for (int k = 6; k >= 0; k--) begin
            s  = s ^ gmul(w[k], xp);
            xp = gmul(xp, x);
        end
        return s;
    endfunction

    function automatic word_t mk(input logic [2:0] a, b, c, d, e, f, g);
        word_t w;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e; w[5] = f; w[6] = g;
        return w;
    endfunction

    function automatic word_t encode(input word_t msg);
        word_t w;
        w = msg;
        for (int p1 = 0; p1 < 8; p1++)
            for (int p0 = 0; p0 < 8; p0++) begin
                w[5] = 3'(p1);
                w[6] = 3'(p0);
                if (synd(w, 3'b010) == 3'b000 && synd(w, 3'b001) == 3'b000) return w;
            end
        return w;
    endfunction

    // Search every single-symbol fix that zeroes both syndromes.
    task automatic model(input word_t r, output word_t o, output logic c, output logic u);
        logic [2:0] a1, a2;
        word_t      t;
        a1 = synd(r, 3'b010);
        a2 = synd(r, 3'b001);
        o = r; c = 1'b0; u = 1'b0;
        if ((a1 == 3'b000) != (a2 == 3'b000)) u = 1'b1;
        else if (a1 != 3'b000)
            for (int p = 0; p < 7; p++)
                for (int m = 1; m < 8; m++) begin
                    t = r;
                    t[p] = t[p] ^ 3'(m);
                    if (synd(t, 3'b010) == 3'b000 && synd(t, 3'b001) == 3'b000) begin
                        o = t; c = 1'b1;
                    end
                end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input word_t w, input int n, input int gapmax);
        int waits;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(gapmax, 0)) begin
                in_valid = 1'b0;
                in_sym   = 3'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_sym   = w[k];
            waits    = 0;
            while (in_ready !== 1'b1 && waits < 40) begin
                @(negedge clk);
                waits++;
            end
            if (waits >= 40) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Entered at the negedge of the CALC cycle; garbage is offered on in_* throughout.
    task automatic recv_word(input word_t ew, input logic ec, input logic eu, input int stall);
        chk("calc_out_valid", 32'(out_valid), 32'd0);
        chk("calc_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_sym   = 3'($urandom);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (stall != 0) begin
                out_ready = 1'b0;
                repeat (3) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_sym", 32'(out_sym), 32'(ew[k]));
                    chk("hold_last", 32'(out_last), 32'(k == 4));
                    chk("hold_corr", 32'(err_corrected), 32'(ec));
                    chk("hold_unc", 32'(err_uncorrectable), 32'(eu));
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                    in_valid = 1'b1;
                    in_sym   = 3'($urandom);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_sym", 32'(out_sym), 32'(ew[k]));
            chk("out_last", 32'(out_last), 32'(k == 4));
            chk("err_corrected", 32'(err_corrected), 32'(ec));
            chk("err_uncorrectable", 32'(err_uncorrectable), 32'(eu));
            chk("send_in_ready", 32'(in_ready), 32'd0);
            in_valid = (k < 4);
            in_sym   = 3'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'($urandom);
        chk("end_out_valid", 32'(out_valid), 32'd0);
        chk("end_flags", 32'({err_corrected, err_uncorrectable, out_last}), 32'd0);
        chk("end_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        word_t clean, w, ref_o, msg;
        logic  ec, eu;
        int    p1, p2;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sym = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sym", 32'(out_sym), 32'd0);
        chk("rst_flags", 32'({err_corrected, err_uncorrectable, out_last}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        clean = mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b011, 3'b110);
        send_word(clean, 7, 0);
        recv_word(clean, 1'b0, 1'b0, 0);

        w = mk(3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        send_word(w, 7, 0);
        recv_word('0, 1'b1, 1'b0, 0);

        w = clean;
        w[6] = 3'b000;
        send_word(w, 7, 0);
        recv_word(clean, 1'b1, 1'b0, 0);

        w = mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010);
        send_word(w, 7, 0);
        recv_word('0, 1'b0, 1'b1, 0);

        send_word(clean, 7, 3);
        recv_word(clean, 1'b0, 1'b0, 1);

        // Abort a half-received block.
        send_word(clean, 4, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrx_in_ready", 32'(in_ready), 32'd0);
        chk("midrx_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        send_word(clean, 7, 0);
        recv_word(clean, 1'b0, 1'b0, 0);

        // Abort while sending: outputs drop and the next block is unaffected.
        w = mk(3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        send_word(w, 7, 0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midtx_out_valid", 32'(out_valid), 32'd0);
        chk("midtx_flags", 32'({err_corrected, err_uncorrectable, out_last}), 32'd0);
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        send_word(clean, 7, 1);
        recv_word(clean, 1'b0, 1'b0, 0);

        for (int b = 0; b < 30; b++) begin
            for (int k = 0; k < 5; k++) msg[k] = 3'($urandom);
            w = encode(msg);
            chk("model_enc", 32'({synd(w, 3'b010), synd(w, 3'b001)}), 32'd0);
            case ($urandom_range(2, 0))
                1: begin
                    p1 = int'($urandom_range(6, 0));
                    w[p1] = w[p1] ^ 3'($urandom_range(7, 1));
                end
                2: begin
                    p1 = int'($urandom_range(6, 0));
                    p2 = (p1 + int'($urandom_range(6, 1))) % 7;
                    w[p1] = w[p1] ^ 3'($urandom_range(7, 1));
                    w[p2] = w[p2] ^ 3'($urandom_range(7, 1));
                end
                default: ;
            endcase
            model(w, ref_o, ec, eu);
            send_word(w, 7, int'($urandom_range(3, 0)));
            recv_word(ref_o, ec, eu, int'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
